// File: rtl/mem_port_arbiter.sv
// Fair two-way arbiter sharing one single-port synchronous word memory
// between the instruction-fetch port and the load/store port.
module mem_port_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_ack,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                ls_req,
   input  logic                ls_we,
   input  logic [DATA_W/8-1:0] ls_be,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic [DATA_W-1:0]   ls_wdata,
   output logic                ls_ack,
   output logic [DATA_W-1:0]   ls_rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic                last_ls;
   logic                last_ls_nxt;
   logic                win_ls;
   logic                win_ls_nxt;
   logic                grant;
   logic                we_q;
   logic [DATA_W-1:0]   if_rdata_q;
   logic [DATA_W-1:0]   ls_rdata_q;

   always_comb begin
      state_nxt   = state;
      win_ls_nxt  = win_ls;
      last_ls_nxt = last_ls;
      grant       = 1'b0;
      unique case (state)
         IDLE: begin
            if (if_req || ls_req) begin
               grant       = 1'b1;
               // On a tie, the side that did not win last time goes first
               win_ls_nxt  = ls_req && (!if_req || !last_ls);
               last_ls_nxt = win_ls_nxt;
               state_nxt   = ACCESS;
            end
         end
         ACCESS:  state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_ls    <= 1'b0;
         win_ls     <= 1'b0;
         we_q       <= 1'b0;
         mem_be     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_rdata_q <= '0;
         ls_rdata_q <= '0;
      end else begin
         state   <= state_nxt;
         last_ls <= last_ls_nxt;
         win_ls  <= win_ls_nxt;
         if (grant) begin
            if (win_ls_nxt) begin
               mem_addr  <= ls_addr;
               we_q      <= ls_we;
               mem_be    <= ls_be;
               mem_wdata <= ls_wdata;
            end else begin
               mem_addr <= if_addr;
               we_q     <= 1'b0;
               mem_be   <= '1;
            end
         end
         if (state == RESP && !we_q) begin
            if (win_ls) ls_rdata_q <= mem_rdata;
            else        if_rdata_q <= mem_rdata;
         end
      end
   end

   assign busy   = (state != IDLE);
   assign mem_en = (state == ACCESS);
   assign mem_we = mem_en && we_q;
   assign if_ack = (state == RESP) && !win_ls;
   assign ls_ack = (state == RESP) && win_ls;

   // Read data is forwarded straight from the array during the ack cycle
   assign if_rdata = if_ack ? mem_rdata : if_rdata_q;
   assign ls_rdata = (ls_ack && !we_q) ? mem_rdata : ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural
// single-port synchronous memory attached to the mem_* port.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [7:0]  if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        ls_req;
   logic        ls_we;
   logic [3:0]  ls_be;
   logic [7:0]  ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_ack;
   logic [31:0] ls_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr),
      .if_ack(if_ack), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be),
      .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_ack(ls_ack), .ls_rdata(ls_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [256];

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= mem[mem_addr];
         end
      end
   end

   int cyc = 0;
   int en_cnt = 0;
   int checks = 0;
   int errors = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (mem_en) en_cnt <= en_cnt + 1;

   typedef struct packed {
      logic        is_ls;
      logic        chk;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];

   task automatic check_ack(input logic is_ls, input logic [31:0] d);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL unexpected_ack: got ls=%0b data=%h, required no ack", is_ls, d);
      end else begin
         e = sb.pop_front();
         if (e.is_ls != is_ls || (e.chk && e.data != d)) begin
            errors++;
            $display("FAIL ack_resp: got ls=%0b data=%h, required ls=%0b data=%h",
                     is_ls, d, e.is_ls, e.data);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (if_ack && ls_ack) begin
            checks++;
            errors++;
            $display("FAIL ack_overlap: got both acks high, required at most one");
         end
         if (if_ack) check_ack(1'b0, if_rdata);
         if (ls_ack) check_ack(1'b1, ls_rdata);
      end
   end

   logic        p_if_pend, p_ls_pend;
   logic [7:0]  p_if_addr, p_ls_addr;
   logic        p_ls_we;
   logic [3:0]  p_ls_be;
   logic [31:0] p_ls_wdata;

   always @(negedge clk) begin
      if (!rst) begin
         if (p_if_pend) assert (if_addr == p_if_addr)
            else $error("if_addr changed while request pending");
         if (p_ls_pend) assert (ls_addr == p_ls_addr && ls_we == p_ls_we &&
                                ls_be == p_ls_be && ls_wdata == p_ls_wdata)
            else $error("ls fields changed while request pending");
      end
      p_if_pend  <= if_req && !if_ack && !rst;
      p_ls_pend  <= ls_req && !ls_ack && !rst;
      p_if_addr  <= if_addr;
      p_ls_addr  <= ls_addr;
      p_ls_we    <= ls_we;
      p_ls_be    <= ls_be;
      p_ls_wdata <= ls_wdata;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   task automatic wait_ack(output int at, output bit ok);
      ok = 1'b0;
      at = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (if_ack || ls_ack) begin
            ok = 1'b1;
            at = cyc;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: got no ack in 10 cycles, required an ack");
      end
   endtask

   task automatic access(input bit is_ls, input bit we, input logic [3:0] be,
                         input logic [7:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp, output int lat);
      int  t0, at;
      bit  ok;
      sb.push_back('{is_ls: is_ls, chk: !we, data: exp});
      @(posedge clk);
      #1;
      if (is_ls) begin
         ls_req = 1'b1; ls_we = we; ls_be = be; ls_addr = addr; ls_wdata = wd;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      t0 = cyc;
      wait_ack(at, ok);
      lat = at - t0;
      @(posedge clk);
      #1;
      if_req = 1'b0;
      ls_req = 1'b0;
   endtask

   task automatic check_quiet(input string name);
      chk(name, {busy, mem_en, mem_we, if_ack, ls_ack, mem_be, mem_addr},
          {5'b0, 4'h0, 8'h00});
      chk({name, "_wdata"}, mem_wdata, 32'h0);
      chk({name, "_rdata"}, if_rdata | ls_rdata, 32'h0);
   endtask

   initial begin
      int lat, at, prev, e0;
      bit ok;
      rst = 1'b1;
      if_req = 1'b0; if_addr = '0;
      ls_req = 1'b0; ls_we = 1'b0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_quiet("reset");
      @(posedge clk);
      #1 rst = 1'b0;

      // Preload the array through the load/store port
      access(1, 1, 4'hF, 8'h04, 32'h00500093, 32'h0, lat);
      access(1, 1, 4'hF, 8'h20, 32'h11223344, 32'h0, lat);
      access(1, 1, 4'hF, 8'h30, 32'hA0A0A0A0, 32'h0, lat);
      access(1, 1, 4'hF, 8'h31, 32'hB1B1B1B1, 32'h0, lat);

      e0 = en_cnt;
      access(0, 0, 4'h0, 8'h04, 32'h0, 32'h00500093, lat);
      chk("fetch_latency", lat, 2);
      chk("fetch_en_cycles", en_cnt - e0, 1);
      chk("fetch_rdata_hold", if_rdata, 32'h00500093);

      access(1, 1, 4'hF, 8'h10, 32'hDEADBEEF, 32'h0, lat);
      access(1, 0, 4'h0, 8'h10, 32'h0, 32'hDEADBEEF, lat);
      chk("load_rdata_hold", ls_rdata, 32'hDEADBEEF);
      chk("if_rdata_kept", if_rdata, 32'h00500093);

      access(1, 1, 4'b0010, 8'h20, 32'h0000AA00, 32'h0, lat);
      access(1, 0, 4'h0, 8'h20, 32'h0, 32'h1122AA44, lat);
      chk("ls_rdata_after_store", ls_rdata, 32'h1122AA44);

      // Contention from reset: LS, IF, LS, IF every 3 cycles
      rst = 1'b1;
      if_req = 1'b1; if_addr = 8'h30;
      ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'h0; ls_addr = 8'h31; ls_wdata = '0;
      sb.push_back('{is_ls: 1'b1, chk: 1'b1, data: 32'hB1B1B1B1});
      sb.push_back('{is_ls: 1'b0, chk: 1'b1, data: 32'hA0A0A0A0});
      sb.push_back('{is_ls: 1'b1, chk: 1'b1, data: 32'hB1B1B1B1});
      sb.push_back('{is_ls: 1'b0, chk: 1'b1, data: 32'hA0A0A0A0});
      @(posedge clk);
      #1 rst = 1'b0;
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         wait_ack(at, ok);
         if (ok && i > 0) chk("ack_spacing", at - prev, 3);
         prev = at;
      end
      @(posedge clk);
      #1;
      if_req = 1'b0;
      ls_req = 1'b0;

      // Reset during the ACCESS cycle of a load
      @(posedge clk);
      #1 ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h31;
      @(posedge clk);
      @(negedge clk);
      chk("rst_pre_access", {busy, mem_en}, 2'b11);
      #1 rst = 1'b1;
      #1 check_quiet("rst_mid_access");
      ls_req = 1'b0;
      @(posedge clk);
      #1;
      sb.push_back('{is_ls: 1'b1, chk: 1'b1, data: 32'hB1B1B1B1});
      sb.push_back('{is_ls: 1'b0, chk: 1'b1, data: 32'hA0A0A0A0});
      if_req = 1'b1; if_addr = 8'h30;
      ls_req = 1'b1;
      rst = 1'b0;
      wait_ack(at, ok);
      wait_ack(at, ok);
      @(posedge clk);
      #1;
      if_req = 1'b0;
      ls_req = 1'b0;

      // Idle
      @(posedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle", {busy, mem_en, if_ack, ls_ack}, 4'b0);
      end

      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
